// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle sequencer: FSM states, instruction
// classes, trap causes, ALUOp codes, opcodes and the opcode decoder.
package multicycle_control_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_e;

  typedef enum logic [2:0] {
    CLS_R  = 3'd0,
    CLS_LD = 3'd1,
    CLS_ST = 3'd2,
    CLS_CB = 3'd3,
    CLS_B  = 3'd4
  } class_e;

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_IMEM    = 2'd2;
  localparam logic [1:0] CAUSE_DMEM    = 2'd3;

  localparam logic [1:0] ALUOP_DTYPE  = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;

  // Exact 11-bit opcodes; CBZ and B carry address bits in their low bits,
  // so they are matched by wildcard patterns in decode_opcode.
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;

  typedef struct packed {
    logic   legal;
    class_e cls;
  } decode_t;

  // Classify an opcode; legal=0 means no instruction pattern matched.
  function automatic decode_t decode_opcode(input logic [10:0] op);
    decode_t d;
    d.legal = 1'b1;
    d.cls   = CLS_R;
    casez (op)
      OP_ADD, OP_SUB, OP_AND, OP_ORR: d.cls = CLS_R;
      OP_LDUR:                        d.cls = CLS_LD;
      OP_STUR:                        d.cls = CLS_ST;
      11'b10110100???:                d.cls = CLS_CB;
      11'b000101?????:                d.cls = CLS_B;
      default:                        d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control bundle between the sequencer and the datapath/memories.
// master = sequencer side, slave = datapath and memory side.
interface multicycle_control_if #(
  parameter int CNT_W = 32
);
  logic [10:0]      opcode;
  logic             zero;
  logic             imem_ack;
  logic             dmem_ack;
  logic             imem_req;
  logic             dmem_req;
  logic             dmem_we;
  logic             ir_write;
  logic             pc_write;
  logic             pc_src;
  logic [1:0]       alu_op;
  logic             alu_src;
  logic             reg_write;
  logic             mem_to_reg;
  logic [2:0]       state;
  logic             trap;
  logic [1:0]       trap_cause;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  opcode, zero, imem_ack, dmem_ack,
    output imem_req, dmem_req, dmem_we, ir_write, pc_write, pc_src,
           alu_op, alu_src, reg_write, mem_to_reg, state, trap,
           trap_cause, instr_count
  );

  modport slave (
    output opcode, zero, imem_ack, dmem_ack,
    input  imem_req, dmem_req, dmem_we, ir_write, pc_write, pc_src,
           alu_op, alu_src, reg_write, mem_to_reg, state, trap,
           trap_cause, instr_count
  );
endinterface

// File: rtl/multicycle_control_timeout.sv
// Handshake wait counter: cleared on request entry, counts waiting cycles,
// flags the last permitted cycle (count == LIMIT-1).
module multicycle_control_timeout #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);
  localparam int W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear has priority over counting.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == LAST);

endmodule

// File: rtl/multicycle_control.sv
// Multicycle sequencer: FETCH/DECODE/EXEC/MEM/WB with memory handshakes,
// retired-instruction counter, and a sticky trap on illegal opcode or
// memory timeout.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input logic               clk,
  input logic               reset,
  multicycle_control_if.master bus
);

  state_e           state_q, state_d;
  class_e           class_q, class_d;
  logic [1:0]       cause_q, cause_d;
  logic [CNT_W-1:0] count_q;
  logic             retire;
  logic             wait_active;
  logic             expired;
  decode_t          dec;

  logic       imem_req, dmem_req, dmem_we, ir_write, pc_write, pc_src;
  logic [1:0] alu_op;
  logic       alu_src, reg_write, mem_to_reg;

  assign dec = decode_opcode(bus.opcode);

  // Counter restarts whenever the FSM changes state or is not waiting on a memory.
  multicycle_control_timeout #(
    .LIMIT (TIMEOUT)
  ) u_timeout (
    .clk       (clk),
    .reset     (reset),
    .clear_i   ((state_d != state_q) || !wait_active),
    .enable_i  (wait_active),
    .expired_o (expired)
  );

  // Next-state and strobe decode; strobes forced low while reset is held.
  always_comb begin
    state_d     = state_q;
    class_d     = class_q;
    cause_d     = cause_q;
    retire      = 1'b0;
    wait_active = 1'b0;
    imem_req    = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_src      = 1'b0;
    alu_op      = ALUOP_DTYPE;
    alu_src     = 1'b0;
    reg_write   = 1'b0;
    mem_to_reg  = 1'b0;

    case (state_q)
      S_FETCH: begin
        imem_req    = 1'b1;
        wait_active = 1'b1;
        if (bus.imem_ack) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end else if (expired) begin
          state_d = S_TRAP;
          cause_d = CAUSE_IMEM;
        end
      end
      S_DECODE: begin
        if (dec.legal) begin
          class_d = dec.cls;
          state_d = S_EXEC;
        end else begin
          state_d = S_TRAP;
          cause_d = CAUSE_ILLEGAL;
        end
      end
      S_EXEC: begin
        case (class_q)
          CLS_R: begin
            alu_op  = ALUOP_RTYPE;
            state_d = S_WB;
          end
          CLS_LD, CLS_ST: begin
            alu_op  = ALUOP_DTYPE;
            alu_src = 1'b1;
            state_d = S_MEM;
          end
          CLS_CB: begin
            alu_op   = ALUOP_BRANCH;
            pc_write = bus.zero;
            pc_src   = 1'b1;
            retire   = 1'b1;
            state_d  = S_FETCH;
          end
          CLS_B: begin
            alu_op   = ALUOP_BRANCH;
            pc_write = 1'b1;
            pc_src   = 1'b1;
            retire   = 1'b1;
            state_d  = S_FETCH;
          end
          default: state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        dmem_req    = 1'b1;
        dmem_we     = (class_q == CLS_ST);
        alu_op      = ALUOP_DTYPE;
        alu_src     = 1'b1;
        wait_active = 1'b1;
        if (bus.dmem_ack) begin
          if (class_q == CLS_ST) begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (expired) begin
          state_d = S_TRAP;
          cause_d = CAUSE_DMEM;
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (class_q == CLS_LD);
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_TRAP: begin
        state_d = S_TRAP;
      end
      default: state_d = S_FETCH;
    endcase

    if (reset) begin
      imem_req   = 1'b0;
      dmem_req   = 1'b0;
      dmem_we    = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 1'b0;
      alu_op     = ALUOP_DTYPE;
      alu_src    = 1'b0;
      reg_write  = 1'b0;
      mem_to_reg = 1'b0;
      retire     = 1'b0;
    end
  end

  // State, class, cause and retire counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      class_q <= CLS_R;
      cause_q <= CAUSE_NONE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      class_q <= class_d;
      cause_q <= cause_d;
      if (retire) begin
        count_q <= count_q + CNT_W'(1);
      end
    end
  end

  assign bus.imem_req    = imem_req;
  assign bus.dmem_req    = dmem_req;
  assign bus.dmem_we     = dmem_we;
  assign bus.ir_write    = ir_write;
  assign bus.pc_write    = pc_write;
  assign bus.pc_src      = pc_src;
  assign bus.alu_op      = alu_op;
  assign bus.alu_src     = alu_src;
  assign bus.reg_write   = reg_write;
  assign bus.mem_to_reg  = mem_to_reg;
  assign bus.state       = state_q;
  assign bus.trap        = (state_q == S_TRAP);
  assign bus.trap_cause  = cause_q;
  assign bus.instr_count = count_q;

endmodule
